// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle unsigned WIDTH x WIDTH multiply / divide unit that drives an
//   external shared ALU. The multiply is shift-add and uses the ALU add
//   (4'b0001). The divide is restoring and uses the ALU subtract (4'b1001).
//   The unit performs one iteration per cycle, 32 iterations per operation.
//
// Ports
//   clk, rst_n           clock (rising edge); asynchronous active-low reset
//   start, op            request (sampled in IDLE only); 0 = MUL, 1 = DIV
//   opa, opb             multiplicand/dividend, multiplier/divisor
//   busy, done           busy through the done cycle; done is a one-cycle pulse
//   hi, lo, dbz          MUL: product[63:32]/[31:0]; DIV: remainder/quotient;
//                        dbz flags a divide by zero
//   alu_a, alu_b         ALU operand outputs
//   alu_control          ALU operation select output
//   alu_result           ALU result input
//   alu_carry            ALU carry input
module muldiv_sequencer #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  DBZ_QUOT = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              op_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  opd_q;    // multiplicand M or divisor D

    logic [WIDTH-1:0]  shifted;  // divide: partial remainder shifted left by one
    logic              take;     // divide: subtraction result is kept

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        alu_control = 4'b0000;
        alu_a       = '0;
        alu_b       = '0;
        shifted     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        // hi_q[MSB] set means the shifted remainder overflowed WIDTH bits, so it
        // is certainly >= D. Carry set means the subtraction did not borrow.
        take        = hi_q[WIDTH-1] | alu_carry;
        if (state_q == StRun) begin
            if (op_q) begin
                alu_control = 4'b1001;
                alu_a       = shifted;
                alu_b       = opd_q;
            end else begin
                alu_control = 4'b0001;
                alu_a       = hi_q;
                alu_b       = lo_q[0] ? opd_q : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        dbz_q  <= 1'b0;
                        op_q   <= op;
                        hi_q   <= '0;
                        if (op && (opb == '0)) begin
                            // Divide by zero: skip the iterations entirely.
                            hi_q    <= opa;
                            lo_q    <= DBZ_QUOT;
                            opd_q   <= opb;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            lo_q    <= op ? opa : opb;
                            opd_q   <= op ? opb : opa;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (op_q) begin
                        hi_q <= take ? alu_result : shifted;
                        lo_q <= {lo_q[WIDTH-2:0], take};
                    end else begin
                        // Add result and carry shift right into {hi, lo}.
                        {hi_q, lo_q} <= {alu_carry, alu_result, lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
